imem_responder: RTL and testbench
=================================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter IWIDTH, default 32, instruction word width.
REQ-002 SHALL have parameter AWIDTH, default 32, byte-address width.
REQ-003 SHALL have parameter DEPTH, default 1024, number of IWIDTH words stored.
REQ-004 SHALL have parameter LATENCY, default 2, number of wait cycles between request capture and ack (0 allowed).
REQ-005 SHALL have port f_clk input 1, clock; all state updates on the rising edge.
REQ-006 SHALL have port f_rst input 1, reset, asynchronous, active-low.
REQ-007 SHALL have port m_i_syn input 1, fetch request strobe from the fetch stage.
REQ-008 SHALL have port m_i_addr input AWIDTH, byte address of the requested instruction.
REQ-009 SHALL have port m_o_instr output IWIDTH, returned instruction word.
REQ-010 SHALL have port m_o_ack output 1, one-cycle pulse marking m_o_instr valid.
REQ-011 SHALL have port m_o_err output 1, qualifies m_o_ack; access was misaligned or out of range.
REQ-012 SHALL have port m_i_wr_en input 1, preload write enable.
REQ-013 SHALL have port m_i_wr_addr input AWIDTH, preload byte address.
REQ-014 SHALL have port m_i_wr_data input IWIDTH, preload data word.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, ACK; reset state IDLE.
REQ-016 SHALL, in IDLE or ACK, capture m_i_addr on an edge where m_i_syn=1; next state is ACK if LATENCY=0, else WAIT with latency counter loaded with LATENCY-1.
REQ-017 SHALL, in WAIT, decrement the counter each edge and enter ACK on the edge the counter is 0.
REQ-018 SHALL, in WAIT, return to IDLE without ack if m_i_syn=0 at an edge (request aborted, e.g. PC redirect).
REQ-019 SHALL drive m_o_ack=1 for exactly the one cycle the FSM is in ACK; m_o_ack is a registered output.
REQ-020 SHALL register m_o_instr on the edge entering ACK and hold it until the next ACK entry.
REQ-021 SHALL, in ACK with m_i_syn=0, return to IDLE; with m_i_syn=1, treat the edge as a new capture per REQ-016 (LATENCY=0 yields one ack per cycle).
REQ-022 SHALL index storage with word index m_i_addr[AWIDTH-1:2].
REQ-023 SHALL, when m_i_addr[1:0]!=0 or word index>=DEPTH, return NOP 32'h00000013 with m_o_err=1 in the ack cycle; m_o_err=0 otherwise and outside ack cycles.
REQ-024 SHALL commit m_i_wr_data on any edge with m_i_wr_en=1 and an aligned in-range m_i_wr_addr; other writes are ignored; writes are accepted in every FSM state.
REQ-025 SHALL, on a write and a read of the same word at the same edge, return the old data (read-before-write).
REQ-026 SHALL ignore changes of m_i_addr after capture.

Reset
REQ-027 SHALL, on f_rst=0, immediately force state IDLE, counter 0, captured address 0, m_o_ack=0, m_o_err=0, m_o_instr=0.
REQ-028 SHALL NOT reset storage contents; a reset during WAIT SHALL discard the pending request with no ack after release.
REQ-029 SHALL capture no request on the first edge after f_rst deasserts unless m_i_syn=1 at that edge.

Structure
REQ-030 SHALL take the FSM state encoding and the NOP constant 32'h00000013 from the shared core package.
REQ-031 SHALL place storage in one sub-module imem_array (synchronous write, synchronous read, DEPTH x IWIDTH); the FSM, counter and error check stay in imem_responder.

Verification
REQ-032 SHALL cover: LATENCY=2, preload word 0x00500093 at 0x0, syn=1 addr 0x0 captured at edge N -> ack=1, instr=0x00500093, err=0 in cycle after edge N+2, exactly one pulse.
REQ-033 SHALL cover: LATENCY=0, syn held 1 with addr 0x0,0x4,0x8 on consecutive edges -> three consecutive ack cycles returning the preloaded words in order.
REQ-034 SHALL cover: LATENCY=3, syn dropped to 0 one edge after capture -> no ack; FSM in IDLE; next request served normally.
REQ-035 SHALL cover: addr 0x2 and addr 4*DEPTH -> ack with instr=0x00000013, err=1.
REQ-036 SHALL cover: f_rst pulsed low while in WAIT -> ack=0 and instr=0 immediately, no ack after release, preloaded contents still readable.
REQ-037 SHALL cover: write 0xDEADBEEF to 0x10 on the same edge that read of 0x10 enters ACK (LATENCY=0) -> old word returned; next read of 0x10 -> 0xDEADBEEF.

Source files
------------

// File: rtl/imem_responder_pkg.sv
// Shared core package for the instruction-memory responder.
//   - imem_state_t : FSM state encoding (IDLE, WAIT, ACK)
//   - NOP_INSTR    : instruction returned on a faulting fetch (addi x0,x0,0)
package imem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } imem_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage : imem_responder_pkg

// File: rtl/imem_array.sv
// DEPTH x IWIDTH instruction storage with one synchronous write port and one
// synchronous read port. A read and a write to the same word on the same edge
// return the old word.
//   f_clk, f_rst        : clock, async active-low reset (read register only)
//   wr_en/wr_idx/wr_data: word-indexed write port
//   rd_en/rd_idx        : word-indexed read request, sampled on the edge
//   rd_data             : registered read data, held while rd_en is low
module imem_array #(
  parameter int IWIDTH = 32,
  parameter int DEPTH  = 1024,
  parameter int IDXW   = 10
) (
  input  logic              f_clk,
  input  logic              f_rst,
  input  logic              wr_en,
  input  logic [IDXW-1:0]   wr_idx,
  input  logic [IWIDTH-1:0] wr_data,
  input  logic              rd_en,
  input  logic [IDXW-1:0]   rd_idx,
  output logic [IWIDTH-1:0] rd_data
);

  logic [IWIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset so it maps onto plain RAM and keeps
  // its preloaded program across a core reset; only the read register resets.
  always_ff @(posedge f_clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // NOTE: non-blocking assignment here is what gives read-before-write: the
  // read samples mem before this edge's write lands.
  always_ff @(posedge f_clk or negedge f_rst) begin
    if (!f_rst)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule : imem_array

// File: rtl/imem_responder.sv
// Instruction-memory responder for the fetch stage. A fetch request is
// captured on m_i_syn, waits LATENCY cycles (abortable by dropping m_i_syn),
// then presents the word with a one-cycle m_o_ack pulse. Misaligned or
// out-of-range fetches return a NOP with m_o_err. A preload write port is
// accepted in every state.
//   f_clk, f_rst                       : clock, async active-low reset
//   m_i_syn, m_i_addr                  : fetch request strobe and byte address
//   m_o_instr, m_o_ack, m_o_err        : returned word, valid pulse, fault flag
//   m_i_wr_en, m_i_wr_addr, m_i_wr_data: preload write port (byte address)
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int IWIDTH  = 32,
  parameter int AWIDTH  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              f_clk,
  input  logic              f_rst,
  input  logic              m_i_syn,
  input  logic [AWIDTH-1:0] m_i_addr,
  output logic [IWIDTH-1:0] m_o_instr,
  output logic              m_o_ack,
  output logic              m_o_err,
  input  logic              m_i_wr_en,
  input  logic [AWIDTH-1:0] m_i_wr_addr,
  input  logic [IWIDTH-1:0] m_i_wr_data
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [CW-1:0]     CNT_LOAD  = (LATENCY > 0) ? CW'(LATENCY - 1) : '0;
  // One extra bit so DEPTH itself is representable next to a word index.
  localparam logic [AWIDTH-2:0] DEPTH_LIM = (AWIDTH-1)'(DEPTH);

  // A byte address is unusable when misaligned or beyond the last word.
  function automatic logic addr_bad(input logic [AWIDTH-1:0] a);
    return (a[1:0] != 2'b00) || ({1'b0, a[AWIDTH-1:2]} >= DEPTH_LIM);
  endfunction

  imem_state_t       state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [AWIDTH-1:0] cap_addr, cap_nxt;
  logic [AWIDTH-1:0] rd_addr;
  logic              ack_entry;
  logic              rd_bad;
  logic              ack_q;
  logic              bad_q;
  logic [IWIDTH-1:0] rd_data;

  // Next-state logic. The read address must be valid in the cycle before the
  // edge that enters ACK: that is the live m_i_addr for a zero-latency
  // capture, otherwise the address captured earlier.
  // NOTE: every signal gets a default first so no path leaves one unassigned
  // (which would infer a latch).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cap_nxt   = cap_addr;
    rd_addr   = cap_addr;
    ack_entry = 1'b0;
    unique case (state)
      IDLE, ACK: begin
        if (m_i_syn) begin
          cap_nxt = m_i_addr;
          rd_addr = m_i_addr;
          if (LATENCY == 0) begin
            state_nxt = ACK;
            ack_entry = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_LOAD;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (!m_i_syn) begin
          // Fetch stage redirected: drop the request silently.
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = ACK;
          ack_entry = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_bad = addr_bad(rd_addr);

  always_ff @(posedge f_clk or negedge f_rst) begin
    if (!f_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cap_addr <= '0;
      ack_q    <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cap_addr <= cap_nxt;
      ack_q    <= ack_entry;
      // bad_q is held with the data so the NOP stays on m_o_instr until the
      // next ACK entry, while m_o_err is only shown during the ack cycle.
      if (ack_entry) bad_q <= rd_bad;
    end
  end

  imem_array #(
    .IWIDTH(IWIDTH),
    .DEPTH (DEPTH),
    .IDXW  (IDXW)
  ) u_array (
    .f_clk  (f_clk),
    .f_rst  (f_rst),
    .wr_en  (m_i_wr_en && !addr_bad(m_i_wr_addr)),
    .wr_idx (m_i_wr_addr[IDXW+1:2]),
    .wr_data(m_i_wr_data),
    .rd_en  (ack_entry && !rd_bad),
    .rd_idx (rd_addr[IDXW+1:2]),
    .rd_data(rd_data)
  );

  assign m_o_ack   = ack_q;
  assign m_o_err   = ack_q && bad_q;
  assign m_o_instr = bad_q ? IWIDTH'(NOP_INSTR) : rd_data;

endmodule : imem_responder

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder. Three instances (LATENCY 0, 2, 3) share
// clock, reset and the preload write port; each has its own fetch port and
// only one is driven at a time. Stimulus pushes the expected word, error flag
// and ack cycle into one queue; a monitor pops on every ack.
module tb_imem_responder;
  import imem_responder_pkg::*;

  localparam int DEPTH = 64;
  localparam int LAT [3] = '{0, 2, 3};

  typedef struct {
    int          dut;
    logic [31:0] instr;
    logic        err;
    int          due;
  } exp_t;

  logic        clk, rst_n;
  logic        syn   [3];
  logic [31:0] addr  [3];
  logic [31:0] instr [3];
  logic        ack   [3];
  logic        err   [3];
  logic        wr_en;
  logic [31:0] wr_addr, wr_data;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   fails  = 0;

  imem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_l0 (
    .f_clk(clk), .f_rst(rst_n), .m_i_syn(syn[0]), .m_i_addr(addr[0]),
    .m_o_instr(instr[0]), .m_o_ack(ack[0]), .m_o_err(err[0]),
    .m_i_wr_en(wr_en), .m_i_wr_addr(wr_addr), .m_i_wr_data(wr_data));

  imem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_l2 (
    .f_clk(clk), .f_rst(rst_n), .m_i_syn(syn[1]), .m_i_addr(addr[1]),
    .m_o_instr(instr[1]), .m_o_ack(ack[1]), .m_o_err(err[1]),
    .m_i_wr_en(wr_en), .m_i_wr_addr(wr_addr), .m_i_wr_data(wr_data));

  imem_responder #(.DEPTH(DEPTH), .LATENCY(3)) u_l3 (
    .f_clk(clk), .f_rst(rst_n), .m_i_syn(syn[2]), .m_i_addr(addr[2]),
    .m_o_instr(instr[2]), .m_o_ack(ack[2]), .m_o_err(err[2]),
    .m_i_wr_en(wr_en), .m_i_wr_addr(wr_addr), .m_i_wr_data(wr_data));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: compare every ack against the queue head; flag stray acks and
  // err asserted outside an ack cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (ack[k]) begin
        if (q.size() == 0) begin
          check($sformatf("unexpected_ack_dut%0d", k), 32'(ack[k]), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check($sformatf("ack_source_dut%0d", k), 32'(k), 32'(e.dut));
          check($sformatf("instr_dut%0d", k), instr[k], e.instr);
          check($sformatf("err_dut%0d", k), 32'(err[k]), 32'(e.err));
          check($sformatf("ack_cycle_dut%0d", k), 32'(cyc), 32'(e.due));
        end
      end else begin
        check($sformatf("err_outside_ack_dut%0d", k), 32'(err[k]), 32'd0);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the ack-entry edge with
  // syn dropped. The address is scrambled right after capture.
  task automatic req(input int k, input logic [31:0] a,
                     input logic [31:0] exp_instr, input logic exp_err);
    syn[k]  = 1'b1;
    addr[k] = a;
    q.push_back('{k, exp_instr, exp_err, cyc + 1 + LAT[k]});
    for (int i = 0; i <= LAT[k]; i++) begin
      @(negedge clk);
      addr[k] = 32'hFFFF_FFF0;
    end
    syn[k] = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_pending"}, 32'(q.size()), 32'd0);
    q.delete();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      syn[k]  = 1'b0;
      addr[k] = '0;
    end
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rst_n   = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state.
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_ack_dut%0d", k), 32'(ack[k]), 32'd0);
      check($sformatf("reset_instr_dut%0d", k), instr[k], 32'd0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Preload; the last two writes are misaligned / out of range and must be
    // dropped (0x100 would alias word 0 if truncated).
    wr(32'h00, 32'h0050_0093);
    wr(32'h04, 32'h0010_0113);
    wr(32'h08, 32'h0020_81B3);
    wr(32'h10, 32'h1111_2222);
    wr(32'hFC, 32'hCAFE_F00D);
    wr(32'h12, 32'hBAD0_BAD0);
    wr(32'h100, 32'h0BAD_F00D);

    // LATENCY=2 single fetch.
    req(1, 32'h0, 32'h0050_0093, 1'b0);
    drain("lat2_single");

    // LATENCY=0 back-to-back fetches, one ack per cycle.
    begin
      logic [31:0] words [3];
      words = '{32'h0050_0093, 32'h0010_0113, 32'h0020_81B3};
      syn[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
        addr[0] = 32'(4 * i);
        q.push_back('{0, words[i], 1'b0, cyc + 1});
        @(negedge clk);
      end
      syn[0] = 1'b0;
    end
    drain("lat0_stream");

    // LATENCY=3 abort one edge after capture, then a normal fetch.
    syn[2]  = 1'b1;
    addr[2] = 32'h4;
    @(negedge clk);
    syn[2] = 1'b0;
    @(negedge clk);
    check("abort_state_idle", 32'(u_l3.state), 32'(IDLE));
    repeat (6) @(negedge clk);
    req(2, 32'h8, 32'h0020_81B3, 1'b0);
    drain("lat3_after_abort");

    // Error cases and the last in-range word.
    req(1, 32'h2, NOP_INSTR, 1'b1);
    req(1, 32'(4 * DEPTH), NOP_INSTR, 1'b1);
    req(1, 32'hFC, 32'hCAFE_F00D, 1'b0);
    req(0, 32'h6, NOP_INSTR, 1'b1);
    drain("errors");
    check("instr_held_after_ack", instr[1], 32'hCAFE_F00D);

    // Reset while LATENCY=3 instance is in WAIT.
    syn[2]  = 1'b1;
    addr[2] = 32'h10;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_in_wait_ack", 32'(ack[2]), 32'd0);
    check("rst_in_wait_instr", instr[2], 32'd0);
    syn[2] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    req(2, 32'h0, 32'h0050_0093, 1'b0);
    req(2, 32'hFC, 32'hCAFE_F00D, 1'b0);
    drain("after_reset");

    // Read-before-write on LATENCY=0 instance, then the new word.
    syn[0]  = 1'b1;
    addr[0] = 32'h10;
    wr_en   = 1'b1;
    wr_addr = 32'h10;
    wr_data = 32'hDEAD_BEEF;
    q.push_back('{0, 32'h1111_2222, 1'b0, cyc + 1});
    @(negedge clk);
    syn[0] = 1'b0;
    wr_en  = 1'b0;
    drain("rbw_old");
    req(0, 32'h10, 32'hDEAD_BEEF, 1'b0);
    drain("rbw_new");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule : tb_imem_responder
